// File: rtl/csoc_scan_pkg.sv
// csoc_scan_pkg: opcodes, response codes and FSM encoding shared by the scan controller.
package csoc_scan_pkg;
  localparam logic [3:0] OP_RST     = 4'h1;
  localparam logic [3:0] OP_MODE    = 4'h2;
  localparam logic [3:0] OP_SHIFT   = 4'h3;
  localparam logic [3:0] OP_CAPTURE = 4'h4;
  localparam logic [3:0] OP_STATUS  = 4'h6;
  localparam logic [7:0] RESP_ERR   = 8'hEE;
  typedef enum logic [2:0] {IDLE, SH_WAIT, SH_PULSE, CAP_PULSE, TX_WAIT, TX_SEND} state_t;
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/csoc_clk_pulser.sv
// csoc_clk_pulser: one csoc_clk pulse per go (HALF_PER low, HALF_PER high); sample marks the last low cycle, done the last high cycle.
module csoc_clk_pulser #(
  parameter int HALF_PER = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic go,
  output logic csoc_clk,
  output logic sample,
  output logic done
);
  localparam int W = $clog2(2 * HALF_PER);
  logic active;
  logic [W-1:0] cnt;
  assign sample = active && cnt == W'(HALF_PER - 1);
  assign done = active && cnt == W'(2 * HALF_PER - 1);
  // go may arrive in the done cycle, giving back-to-back pulses with no extra idle cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      active <= 1'b0;
      cnt <= '0;
      csoc_clk <= 1'b0;
    end else if (go) begin
      active <= 1'b1;
      cnt <= '0;
      csoc_clk <= 1'b0;
    end else if (done) begin
      active <= 1'b0;
      csoc_clk <= 1'b0;
    end else if (active) begin
      cnt <= cnt + 1'b1;
      csoc_clk <= csoc_clk | sample;
    end
  end
endmodule

// File: rtl/csoc_scan_ctrl.sv
// csoc_scan_ctrl: UART-byte-driven scan-chain controller for the CSoC test harness.
// Define CSOC_SCAN_CHKSUM_EN to append an XOR checksum byte after each SHIFT.
module csoc_scan_ctrl
  import csoc_scan_pkg::*;
#(
  parameter int NUM_CHAINS = 8,
  parameter int CHAIN_LEN  = 64,
  parameter int HALF_PER   = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  rx_rcv,
  input  logic [7:0]            rx_data,
  input  logic                  tx_ready,
  output logic                  tx_start,
  output logic [7:0]            tx_data,
  output logic                  busy,
  output logic                  csoc_reset,
  output logic                  csoc_test_tm,
  output logic                  csoc_test_se,
  output logic                  csoc_clk,
  output logic [NUM_CHAINS-1:0] csoc_data_o,
  input  logic [NUM_CHAINS-1:0] csoc_data_i
);
  localparam int CW = cnt_w(CHAIN_LEN);
  state_t state, nxt;
  logic [CW-1:0] sh_cnt;
  logic [4:0] cap_cnt;
  logic [NUM_CHAINS-1:0] samp;
  logic [7:0] resp;
  logic [3:0] op;
  logic overflow, go, sample, done, last;
`ifdef CSOC_SCAN_CHKSUM_EN
  logic [7:0] acc;
  logic chk_pend;
`endif
  assign op = rx_data[7:4];
  assign resp = 8'(samp);
  assign last = sh_cnt == CW'(1);
  assign busy = state != IDLE;
  // Starting the pulse on the accepting edge puts the rising edge HALF_PER cycles after data_o/se settle.
  assign go = (rx_rcv && ((state == IDLE && op == OP_CAPTURE) || state == SH_WAIT))
           || (state == CAP_PULSE && done && cap_cnt != 5'd1);
  csoc_clk_pulser #(.HALF_PER(HALF_PER)) u_pulser (
    .clk(clk),
    .rstn(rstn),
    .go(go),
    .csoc_clk(csoc_clk),
    .sample(sample),
    .done(done)
  );
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      nxt <= IDLE;
      sh_cnt <= '0;
      cap_cnt <= '0;
      samp <= '0;
      overflow <= 1'b0;
      tx_start <= 1'b0;
      tx_data <= '0;
      csoc_reset <= 1'b1;
      csoc_test_tm <= 1'b0;
      csoc_test_se <= 1'b0;
      csoc_data_o <= '0;
`ifdef CSOC_SCAN_CHKSUM_EN
      acc <= '0;
      chk_pend <= 1'b0;
`endif
    end else begin
      tx_start <= 1'b0;
      if (rx_rcv && state != IDLE && state != SH_WAIT) overflow <= 1'b1;
      if (sample) samp <= csoc_data_i;
      case (state)
        IDLE: if (rx_rcv) begin
          nxt <= IDLE;
          state <= TX_SEND;
          tx_data <= rx_data;
          case (op)
            OP_RST: csoc_reset <= rx_data[0];
            OP_MODE: csoc_test_tm <= rx_data[0];
            OP_SHIFT: begin
              csoc_test_se <= 1'b1;
              sh_cnt <= CW'(CHAIN_LEN);
              state <= SH_WAIT;
`ifdef CSOC_SCAN_CHKSUM_EN
              acc <= '0;
              chk_pend <= 1'b0;
`endif
            end
            OP_CAPTURE: begin
              csoc_test_se <= 1'b0;
              cap_cnt <= (rx_data[3:0] == 4'h0) ? 5'd16 : {1'b0, rx_data[3:0]};
              state <= CAP_PULSE;
            end
            OP_STATUS: begin
              tx_data <= {overflow, csoc_test_tm, csoc_test_se, csoc_reset, 4'h0};
              overflow <= 1'b0;
            end
            default: tx_data <= RESP_ERR;
          endcase
        end
        SH_WAIT: if (rx_rcv) begin
          csoc_data_o <= rx_data[NUM_CHAINS-1:0];
          state <= SH_PULSE;
        end
        SH_PULSE: if (done) begin
          tx_data <= resp;
          sh_cnt <= sh_cnt - 1'b1;
          nxt <= last ? IDLE : SH_WAIT;
          csoc_test_se <= !last;
          state <= TX_SEND;
`ifdef CSOC_SCAN_CHKSUM_EN
          acc <= acc ^ resp;
          chk_pend <= last;
`endif
        end
        CAP_PULSE: if (done) begin
          cap_cnt <= cap_cnt - 1'b1;
          state <= (cap_cnt == 5'd1) ? TX_SEND : CAP_PULSE;
        end
        TX_SEND: if (tx_ready) begin
          tx_start <= 1'b1;
          state <= TX_WAIT;
        end
        // tx_ready still reflects the idle uart in the cycle right after tx_start, so skip it.
        TX_WAIT: if (!tx_start && tx_ready) begin
`ifdef CSOC_SCAN_CHKSUM_EN
          if (chk_pend) begin
            tx_data <= acc;
            chk_pend <= 1'b0;
            state <= TX_SEND;
          end else state <= nxt;
`else
          state <= nxt;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_csoc_scan_ctrl.sv
// tb_csoc_scan_ctrl: table vectors, hand-written corner sequences and random commands against a byte-level model.
module tb_csoc_scan_ctrl;
  localparam int NC = 8, CL = 4, HP = 3;
  logic clk = 1'b0, rstn = 1'b0, rx_rcv = 1'b0, tx_ready = 1'b1;
  logic [7:0] rx_data = '0;
  logic tx_start, busy, csoc_reset, csoc_test_tm, csoc_test_se, csoc_clk;
  logic [7:0] tx_data;
  logic [NC-1:0] csoc_data_o, csoc_data_i, loop_q, inv;
  int total = 0, bad = 0, cyc = 0, t_rx = 0;
  csoc_scan_ctrl #(.NUM_CHAINS(NC), .CHAIN_LEN(CL), .HALF_PER(HP)) dut (
    .clk(clk), .rstn(rstn), .rx_rcv(rx_rcv), .rx_data(rx_data), .tx_ready(tx_ready),
    .tx_start(tx_start), .tx_data(tx_data), .busy(busy), .csoc_reset(csoc_reset),
    .csoc_test_tm(csoc_test_tm), .csoc_test_se(csoc_test_se), .csoc_clk(csoc_clk),
    .csoc_data_o(csoc_data_o), .csoc_data_i(csoc_data_i)
  );
  always #5 clk = ~clk;
  initial begin
    loop_q = '0;
    inv = '0;
  end
  always @(posedge clk) begin
    cyc++;
    loop_q <= csoc_data_o;
  end
  assign csoc_data_i = loop_q ^ inv;
  // uart_tx stand-in: records each byte, holds tx_ready low tx_busy cycles, checks tx_data stays put
  logic [7:0] rq[$];
  int tq[$];
  int tx_busy = 2, tx_cnt = 0, stab_err = 0, start_err = 0;
  initial begin : uart
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (tx_start && rstn) begin
        if (!tx_ready) start_err++;
        b = tx_data;
        rq.push_back(b);
        tq.push_back(cyc);
        tx_cnt++;
        tx_ready = 1'b0;
        repeat (tx_busy) begin
          @(negedge clk);
          if (rstn && tx_data !== b) stab_err++;
        end
        tx_ready = 1'b1;
      end
    end
  end
  int pulses = 0, hi_len = 0, hi_bad = 0, rise_se0 = 0, rise_se1 = 0, since_chg = 0, early = 0;
  logic clk_prev = 1'b0;
  logic [NC-1:0] do_prev = '0;
  always @(negedge clk) begin
    if (!rstn) begin
      clk_prev = 1'b0;
      hi_len = 0;
    end
    if (csoc_data_o !== do_prev) since_chg = 0;
    else since_chg++;
    do_prev = csoc_data_o;
    if (csoc_clk && !clk_prev) begin
      pulses++;
      if (csoc_test_se) rise_se1++;
      else rise_se0++;
      if (since_chg < HP) early++;
    end
    if (csoc_clk) hi_len++;
    else begin
      if (clk_prev && hi_len != HP) hi_bad++;
      hi_len = 0;
    end
    clk_prev = csoc_clk;
  end
  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic logic [31:0] pins();
    return 32'({csoc_reset, csoc_test_tm, csoc_test_se, csoc_clk, busy, tx_start, tx_data, csoc_data_o});
  endfunction
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_rcv = 1'b1;
    t_rx = cyc;
    @(negedge clk);
    rx_rcv = 1'b0;
  endtask
  task automatic get(input string nm, output logic [7:0] b, output int lat);
    int n = 0;
    while (rq.size() == 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (rq.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: no tx_start within %0d cycles", nm, n);
      b = 'x;
      lat = -1;
    end else begin
      b = rq.pop_front();
      lat = tq.pop_front() - t_rx;
    end
  endtask
  task automatic settle();
    int n = 0;
    while (!tx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
  endtask
  // reference model: the host-visible state only
  logic m_rst = 1'b1, m_tm = 1'b0, m_ovf = 1'b0;
  task automatic do_cmd(input logic [7:0] c, input string nm);
    logic [7:0] r, e;
    int lat, p0, s1;
    p0 = pulses;
    s1 = rise_se1;
    e = 8'hEE;
    if (c[7:4] == 4'h1) begin m_rst = c[0]; e = c; end
    if (c[7:4] == 4'h2) begin m_tm = c[0]; e = c; end
    if (c[7:4] == 4'h4) e = c;
    if (c[7:4] == 4'h6) e = {m_ovf, m_tm, 1'b0, m_rst, 4'h0};
    send(c);
    if (c[7:4] == 4'h6) m_ovf = 1'b0;
    get(nm, r, lat);
    chk(nm, 32'(r), 32'(e));
    if (c[7:4] == 4'h4) begin
      chk({nm, "_pulses"}, 32'(pulses - p0), (c[3:0] == 4'h0) ? 32'd16 : 32'(c[3:0]));
      chk({nm, "_se_at_rise"}, 32'(rise_se1 - s1), 32'd0);
    end else chk({nm, "_latency"}, 32'(lat), 32'd2);
    settle();
    chk({nm, "_pins"}, 32'({csoc_reset, csoc_test_tm, csoc_test_se, busy}), 32'({m_rst, m_tm, 2'b00}));
  endtask
  task automatic do_shift(input logic [7:0] d [CL], input string nm);
    logic [7:0] r, e, acc;
    int lat, p0, s0;
    p0 = pulses;
    s0 = rise_se0;
    acc = '0;
    send(8'h30);
    chk({nm, "_se_on"}, 32'(csoc_test_se), 32'd1);
    repeat (3) @(negedge clk);
    chk({nm, "_no_ack"}, 32'(rq.size()), 32'd0);
    for (int i = 0; i < CL; i++) begin
      send(d[i]);
      e = 8'(d[i][NC-1:0] ^ inv);
      acc ^= e;
      get(nm, r, lat);
      chk($sformatf("%s_resp%0d", nm, i), 32'(r), 32'(e));
      chk($sformatf("%s_latency%0d", nm, i), 32'(lat), 32'(2 * HP + 2));
      settle();
    end
`ifdef CSOC_SCAN_CHKSUM_EN
    get({nm, "_chksum"}, r, lat);
    chk({nm, "_chksum"}, 32'(r), 32'(acc));
    settle();
`endif
    chk({nm, "_pulses"}, 32'(pulses - p0), 32'(CL));
    chk({nm, "_se_at_rise"}, 32'(rise_se0 - s0), 32'd0);
    chk({nm, "_se_off_idle"}, 32'({csoc_test_se, busy}), 32'd0);
  endtask
  typedef struct {
    logic [7:0] cmd;
    logic [7:0] resp;
    logic       rst;
    logic       tm;
  } vec_t;
  vec_t tbl [14];
  logic [3:0] bad_ops [11];
  initial begin
    logic [7:0] d [CL];
    logic [7:0] r, c;
    int lat, c0, sel;
    tbl = '{'{8'h60, 8'h10, 1'b1, 1'b0}, '{8'h10, 8'h10, 1'b0, 1'b0}, '{8'h21, 8'h21, 1'b0, 1'b1},
            '{8'h60, 8'h40, 1'b0, 1'b1}, '{8'h90, 8'hEE, 1'b0, 1'b1}, '{8'h60, 8'h40, 1'b0, 1'b1},
            '{8'h1F, 8'h1F, 1'b1, 1'b1}, '{8'h60, 8'h50, 1'b1, 1'b1}, '{8'h2E, 8'h2E, 1'b1, 1'b0},
            '{8'h05, 8'hEE, 1'b1, 1'b0}, '{8'hF6, 8'hEE, 1'b1, 1'b0}, '{8'h60, 8'h10, 1'b1, 1'b0},
            '{8'h7A, 8'hEE, 1'b1, 1'b0}, '{8'h10, 8'h10, 1'b0, 1'b0}};
    bad_ops = '{4'h0, 4'h5, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
    repeat (3) @(negedge clk);
    chk("reset_values", pins(), 32'h0020_0000);
    rstn = 1'b1;
    @(negedge clk);
    foreach (tbl[i]) begin
      send(tbl[i].cmd);
      get("tbl", r, lat);
      chk($sformatf("tbl%0d_resp", i), 32'(r), 32'(tbl[i].resp));
      chk($sformatf("tbl%0d_latency", i), 32'(lat), 32'd2);
      settle();
      chk($sformatf("tbl%0d_pins", i), 32'({csoc_reset, csoc_test_tm, csoc_test_se, busy}),
          32'({tbl[i].rst, tbl[i].tm, 2'b00}));
    end
    m_rst = tbl[13].rst;
    m_tm = tbl[13].tm;
    d = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
    do_shift(d, "shift");
    do_cmd(8'h43, "cap3");
    do_cmd(8'h40, "cap16");
    do_cmd(8'h90, "bad_op");
    // byte arriving while the capture echo is still in flight is dropped and flagged
    tx_busy = 30;
    send(8'h41);
    get("ovf_cap", r, lat);
    chk("ovf_cap", 32'(r), 32'h41);
    repeat (3) @(negedge clk);
    send({7'h08, ~m_rst});
    settle();
    tx_busy = 2;
    repeat (4) @(negedge clk);
    chk("ovf_no_resp", 32'(rq.size()), 32'd0);
    chk("ovf_dropped", 32'(csoc_reset), 32'(m_rst));
    m_ovf = 1'b1;
    do_cmd(8'h60, "status_ovf");
    do_cmd(8'h60, "status_clr");
    // reset in the middle of a shift pulse
    send(8'h30);
    send(8'h5A);
    repeat (HP + 1) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("rst_mid_shift", pins(), 32'h0020_0000);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    rq.delete();
    tq.delete();
    c0 = tx_cnt;
    repeat (40) @(negedge clk);
    chk("rst_no_tx", 32'(tx_cnt - c0), 32'd0);
    chk("rst_idle", 32'(busy), 32'd0);
    m_rst = 1'b1;
    m_tm = 1'b0;
    m_ovf = 1'b0;
    do_cmd(8'h60, "rst_status");
    for (int k = 0; k < 24; k++) begin
      tx_busy = $urandom_range(1, 4);
      sel = $urandom_range(0, 5);
      if (sel == 5) begin
        inv = NC'($urandom);
        foreach (d[i]) d[i] = 8'($urandom);
        do_shift(d, "rnd_shift");
        inv = '0;
      end else begin
        c = sel == 0 ? {4'h1, 4'($urandom)} :
            sel == 1 ? {4'h2, 4'($urandom)} :
            sel == 2 ? 8'h60 :
            sel == 3 ? {4'h4, 4'($urandom_range(0, 4))} :
                       {bad_ops[$urandom_range(0, 10)], 4'($urandom)};
        do_cmd(c, $sformatf("rnd%0d_%02h", k, c));
      end
    end
    chk("tx_data_stable", 32'(stab_err), 32'd0);
    chk("tx_start_ready", 32'(start_err), 32'd0);
    chk("clk_high_len", 32'(hi_bad), 32'd0);
    chk("data_setup", 32'(early), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
